// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the FPGA configuration loader.
//   - cfg_state_e : loader FSM state encoding (ST_CRC exists only when the
//                   CONFIG_CRC_EN macro is defined)
//   - CRC8_POLY / CRC8_INIT : CRC-8 checksum constants
//   - word_count  : number of cfg words needed to fill a chain of len bits
//   - crc8_step   : one serial CRC-8 update, MSB-first register
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLB  = 3'd1,
    ST_CONN = 3'd2,
    ST_DONE = 3'd3
`ifdef CONFIG_CRC_EN
    , ST_CRC = 3'd4
`endif
  } cfg_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  function automatic int word_count(input int len, input int width);
    return (len + width - 1) / width;
  endfunction

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/cfg_shift_unit.sv
// Word buffer, per-chain bit counter and scan_clk phase generator.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   run               : a chain is being shifted (CLB or CONN)
//   more_chains       : another chain follows the current one
//   chain_len         : bit length of the current chain
//   cfg_data/valid    : incoming bitstream word
//   cfg_ready         : buffer empty and a bit is needed now
//   scan_clk          : registered shift clock (phase 0 low, phase 1 high)
//   shift_now         : this edge presents a new bit (phase 0 begins)
//   shift_bit         : the bit presented when shift_now is high
//   chain_end         : this edge completes phase 1 of the chain's last bit
//
// Handshake: a word transfers on a clk edge where cfg_valid && cfg_ready;
// cfg_ready depends only on registered state, never on cfg_valid.
module cfg_shift_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  more_chains,
  input  logic [CNT_W-1:0]      chain_len,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  scan_clk,
  output logic                  shift_now,
  output logic                  shift_bit,
  output logic                  chain_end
);

  localparam int BC_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] word_q;
  logic [BC_W-1:0]       word_bits;  // unshifted bits left in word_q
  logic [CNT_W-1:0]      bit_cnt;    // bits presented so far in this chain
  logic                  ph0;        // a bit is on the wire in phase 0
  logic                  want_bit;
  logic                  word_empty;

  // At a chain boundary the leftover word bits are dropped and the next
  // chain's first bit may be presented on the same edge, so the boundary
  // costs no idle cycle with a back-to-back source.
  always_comb begin
    chain_end  = run && !ph0 && scan_clk && (bit_cnt == chain_len);
    word_empty = chain_end || (word_bits == '0);
    if (!run || ph0)    want_bit = 1'b0;
    else if (chain_end) want_bit = more_chains;
    else                want_bit = (bit_cnt < chain_len);
    cfg_ready = want_bit && word_empty;
    shift_now = want_bit && (!word_empty || cfg_valid);
    shift_bit = word_empty ? cfg_data[0] : word_q[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q    <= '0;
      word_bits <= '0;
      bit_cnt   <= '0;
      ph0       <= 1'b0;
      scan_clk  <= 1'b0;
    end else if (ph0) begin
      scan_clk <= 1'b1;
      ph0      <= 1'b0;
    end else begin
      // Any cycle without a presented bit keeps scan_clk low (stall).
      scan_clk <= 1'b0;
      if (shift_now) begin
        ph0     <= 1'b1;
        bit_cnt <= (chain_end ? '0 : bit_cnt) + CNT_W'(1);
        if (word_empty) begin
          word_q    <= cfg_data >> 1;
          word_bits <= BC_W'(DATA_WIDTH - 1);
        end else begin
          word_q    <= word_q >> 1;
          word_bits <= word_bits - BC_W'(1);
        end
      end else if (chain_end) begin
        bit_cnt   <= '0;
        word_bits <= '0;
      end
    end
  end

endmodule

// File: rtl/fpga_config_loader.sv
// Bitstream loader for the 2x2 fpga_top: streams cfg words into the CLB scan
// chain, then the connection scan chain, and releases the fabric clock.
// Optional macro CONFIG_CRC_EN adds a trailing CRC-8 word check (crc_err).
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   start                        : begin a pass from IDLE or DONE
//   cfg_data, cfg_valid/ready    : word stream (transfer on valid && ready)
//   busy, done, fpga_clk_en      : pass status; fpga_clk_en mirrors done
//   scan_clk                     : clk/2 shift clock while shifting
//   clb_scan_in/en               : CLB chain data and enable
//   conn_scan_in/en              : connection chain data and enable
//   crc_err                      : trailing CRC mismatch (0 without the macro)
//   state_dbg                    : current FSM state (cfg_state_e encoding)
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int CLB_CHAIN_LEN  = 64,
  parameter int CONN_CHAIN_LEN = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  fpga_clk_en,
  output logic                  scan_clk,
  output logic                  clb_scan_in,
  output logic                  clb_scan_en,
  output logic                  conn_scan_in,
  output logic                  conn_scan_en,
  output logic                  crc_err,
  output logic [2:0]            state_dbg
);

  localparam int MAX_LEN = (CLB_CHAIN_LEN > CONN_CHAIN_LEN) ? CLB_CHAIN_LEN : CONN_CHAIN_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  cfg_state_e       state;
  logic             run;
  logic             more_chains;
  logic [CNT_W-1:0] chain_len;
  logic             su_ready;
  logic             shift_now;
  logic             shift_bit;
  logic             chain_end;

  assign run         = (state == ST_CLB) || (state == ST_CONN);
  assign more_chains = (state == ST_CLB);
  assign chain_len   = more_chains ? CNT_W'(CLB_CHAIN_LEN) : CNT_W'(CONN_CHAIN_LEN);
  assign fpga_clk_en = done;
  assign state_dbg   = state;

  cfg_shift_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_shift (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .more_chains (more_chains),
    .chain_len   (chain_len),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (su_ready),
    .scan_clk    (scan_clk),
    .shift_now   (shift_now),
    .shift_bit   (shift_bit),
    .chain_end   (chain_end)
  );

`ifdef CONFIG_CRC_EN
  logic [7:0] crc_q;
  assign cfg_ready = su_ready || (state == ST_CRC);
`else
  assign cfg_ready = su_ready;
  assign crc_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      clb_scan_in  <= 1'b0;
      clb_scan_en  <= 1'b0;
      conn_scan_in <= 1'b0;
      conn_scan_en <= 1'b0;
`ifdef CONFIG_CRC_EN
      crc_q        <= CRC8_INIT;
      crc_err      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_CLB;
            busy  <= 1'b1;
            done  <= 1'b0;
`ifdef CONFIG_CRC_EN
            crc_q   <= CRC8_INIT;
            crc_err <= 1'b0;
`endif
          end
        end
        ST_CLB: begin
          if (chain_end) state <= ST_CONN;
        end
        ST_CONN: begin
          if (chain_end) begin
`ifdef CONFIG_CRC_EN
            state <= ST_CRC;
`else
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`endif
          end
        end
`ifdef CONFIG_CRC_EN
        ST_CRC: begin
          if (cfg_valid) begin
            crc_err <= (8'(cfg_data) != crc_q);
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase

      // A bit presented on the CLB->CONN boundary edge belongs to CONN.
      if (shift_now) begin
        if ((state == ST_CLB) && !chain_end) begin
          clb_scan_en  <= 1'b1;
          clb_scan_in  <= shift_bit;
          conn_scan_en <= 1'b0;
          conn_scan_in <= 1'b0;
        end else begin
          clb_scan_en  <= 1'b0;
          clb_scan_in  <= 1'b0;
          conn_scan_en <= 1'b1;
          conn_scan_in <= shift_bit;
        end
`ifdef CONFIG_CRC_EN
        crc_q <= crc8_step(crc_q, shift_bit);
`endif
      end else if (chain_end) begin
        clb_scan_en  <= 1'b0;
        clb_scan_in  <= 1'b0;
        conn_scan_en <= 1'b0;
        conn_scan_in <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Directed bench for fpga_config_loader (DATA_WIDTH=4, chains 5 and 6 bits).
module tb_fpga_config_loader;
  import fpga_cfg_pkg::*;

  localparam int DW       = 4;
  localparam int CLB_LEN  = 5;
  localparam int CONN_LEN = 6;
`ifdef CONFIG_CRC_EN
  localparam int EXTRA = 1;
  localparam int LAT   = 23;
`else
  localparam int EXTRA = 0;
  localparam int LAT   = 22;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready, busy, done, fpga_clk_en, scan_clk;
  logic          clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en, crc_err;
  logic [2:0]    state_dbg;

  fpga_config_loader #(
    .DATA_WIDTH     (DW),
    .CLB_CHAIN_LEN  (CLB_LEN),
    .CONN_CHAIN_LEN (CONN_LEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .busy         (busy),
    .done         (done),
    .fpga_clk_en  (fpga_clk_en),
    .scan_clk     (scan_clk),
    .clb_scan_in  (clb_scan_in),
    .clb_scan_en  (clb_scan_en),
    .conn_scan_in (conn_scan_in),
    .conn_scan_en (conn_scan_en),
    .crc_err      (crc_err),
    .state_dbg    (state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [DW-1:0] src_q[$];
  logic [0:0]    exp_q[$];
  logic [0:0]    clb_got[$];
  logic [0:0]    conn_got[$];

  int sc_rises   = 0;
  int overlap    = 0;
  int t0         = 0;
  int td         = 0;
  bit t0_ok      = 1'b0;
  bit td_ok      = 1'b0;
  int stall_left = 0;
  bit stall_arm  = 1'b0;
  int stall_hi   = 0;
  int stall_hits = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: word source with optional 10-cycle stall on the 2nd CONN word
  initial begin
    cfg_valid = 1'b0;
    cfg_data  = '0;
    forever begin
      @(negedge clk);
      if (stall_left > 0) begin
        if (scan_clk) stall_hi++;
        stall_left--;
      end else if (stall_arm && cfg_ready && (src_q.size() == 1 + EXTRA)) begin
        stall_arm  = 1'b0;
        stall_left = 10;
        stall_hits++;
      end
      cfg_valid = (src_q.size() > 0) && (stall_left == 0);
      cfg_data  = (src_q.size() > 0) ? src_q[0] : '0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst && cfg_valid && cfg_ready && (src_q.size() > 0)) void'(src_q.pop_front());
    end
  end

  // monitors: scan bits captured on scan_clk rising edges, timing, overlap
  initial begin
    forever begin
      @(posedge scan_clk);
      sc_rises++;
      if (clb_scan_en)  clb_got.push_back(clb_scan_in);
      if (conn_scan_en) conn_got.push_back(conn_scan_in);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (clb_scan_en && conn_scan_en) overlap++;
      if (!t0_ok && clb_scan_en) begin t0 = cyc; t0_ok = 1'b1; end
      if (!td_ok && done)        begin td = cyc; td_ok = 1'b1; end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fpga_clk_en"}, fpga_clk_en, 0);
    check({tag, "_scan_clk"}, scan_clk, 0);
    check({tag, "_clb_io"}, {clb_scan_en, clb_scan_in}, 0);
    check({tag, "_conn_io"}, {conn_scan_en, conn_scan_in}, 0);
    check({tag, "_crc_err"}, crc_err, 0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  task automatic load_words(input logic [15:0] words, input logic [DW-1:0] tail);
    src_q.delete();
    for (int k = 0; k < 4; k++) src_q.push_back(words[k*DW +: DW]);
    if (EXTRA != 0) src_q.push_back(tail);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic compare_bits(input string tag, input logic [0:0] got[$], input logic [5:0] bits, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(bits[i]);
    check($sformatf("%s_count", tag), got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      check($sformatf("%s_bit%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic run_pass(input string name, input logic [15:0] words, input logic [DW-1:0] tail,
                          input logic [4:0] clb_bits, input logic [5:0] conn_bits,
                          input int exp_lat, input logic exp_crc_err, input bit poke);
    load_words(words, tail);
    @(negedge clk);
    pulse_start();
    // monitors restart once done has dropped for this pass
    t0_ok = 1'b0; td_ok = 1'b0; sc_rises = 0; overlap = 0;
    clb_got.delete(); conn_got.delete();
    check({name, "_busy_after_start"}, busy, 1);
    check({name, "_done_after_start"}, done, 0);
    if (poke) begin
      repeat (3) @(negedge clk);
      pulse_start();
      check({name, "_start_ignored_state"}, state_dbg, ST_CLB);
      check({name, "_start_ignored_busy"}, busy, 1);
    end
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    check({name, "_done_reached"}, done, 1);
    check({name, "_latency"}, td - t0, exp_lat);
    repeat (6) @(negedge clk);
    compare_bits({name, "_clb"}, clb_got, {1'b0, clb_bits}, CLB_LEN);
    compare_bits({name, "_conn"}, conn_got, conn_bits, CONN_LEN);
    check({name, "_scan_clk_rises"}, sc_rises, CLB_LEN + CONN_LEN);
    check({name, "_en_overlap"}, overlap, 0);
    check({name, "_fpga_clk_en"}, fpga_clk_en, 1);
    check({name, "_busy_done"}, busy, 0);
    check({name, "_ready_done"}, cfg_ready, 0);
    check({name, "_state_done"}, state_dbg, ST_DONE);
    check({name, "_crc_err"}, crc_err, (EXTRA != 0) ? exp_crc_err : 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // pass a: 0x5,0x1,0xA,0x3; CRC of bits = 0xE3 so tail 0x3 mismatches
    run_pass("a", 16'h3A15, 4'h3, 5'b10101, 6'b111010, LAT, 1'b1, 1'b1);

    // pass b: start from DONE, 10-cycle stall; bits form the CRC polynomial -> CRC 0x00
    check("b_done_before", done, 1);
    stall_arm = 1'b1;
    stall_hits = 0;
    stall_hi = 0;
    run_pass("b", 16'hF8E4, 4'h0, 5'b00100, 6'b111000, LAT + 10, 1'b0, 1'b0);
    check("b_stall_taken", stall_hits, 1);
    check("b_stall_scan_clk_high", stall_hi, 0);

    // pass c: reset on the third CONN bit
    load_words(16'h3A15, 4'h3);
    @(negedge clk);
    pulse_start();
    conn_got.delete();
    for (int i = 0; i < 200 && conn_got.size() < 2; i++) @(negedge clk);
    check("c_conn_bits_seen", conn_got.size(), 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("c_rst");
    rst = 1'b0;
    src_q.delete();
    @(negedge clk);
    check_all_zero("c_after_rst");

    // pass d: fresh start after the aborted pass reloads both chains
    run_pass("d", 16'h3A15, 4'h3, 5'b10101, 6'b111010, LAT, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
